wb_stage: RTL and testbench

- Writeback stage directly upstream of the register file.
- Merges results from the single-cycle ALU path and the load/store unit (LSU) onto the regfile's single write port (RF_W, rdc, rd).
- Extracts and sign/zero-extends LSU load data, buffers LSU results in a small FIFO, and suppresses writes to x0.
- Its registered outputs drive the regfile write port directly and also serve as the decode-stage bypass source.

---
 rtl/wb_pkg.sv | 37 +++
 rtl/wb_if.sv | 34 +++
 rtl/wb_fifo.sv | 58 +++++
 rtl/wb_stage.sv | 107 ++++++++++
 tb/tb_wb_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: datapath width, load
// opcodes, buffered LSU entry layout and the load legality checks.
package wb_pkg;

  localparam int XLEN = 64;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LD  = 3'b011,
    LBU = 3'b100,
    LHU = 3'b101,
    LWU = 3'b110
  } load_op_t;

  typedef struct packed {
    logic [4:0]      rdc;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // funct3[1:0] encodes access size; funct3=111 is rejected separately.
  function automatic logic load_misaligned(input logic [2:0] funct3,
                                           input logic [2:0] addr_lo);
    case (funct3[1:0])
      2'b01:   return addr_lo[0];
      2'b10:   return |addr_lo[1:0];
      2'b11:   return |addr_lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic load_illegal(input logic [2:0] funct3);
    return funct3 == 3'b111;
  endfunction

endpackage

// File: rtl/wb_if.sv
// Bundle of the ALU/LSU result handshakes and the regfile write port seen by
// the writeback stage.
interface wb_if;
  import wb_pkg::*;

  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rdc;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rdc;
  logic [XLEN-1:0] lsu_data;
  logic [2:0]      lsu_addr_lo;
  logic [2:0]      lsu_funct3;
  logic            RF_W;
  logic [4:0]      rdc;
  logic [XLEN-1:0] rd;
  logic            lsu_err;
  logic            lsu_busy;

  modport slave (
    input  alu_valid, alu_rdc, alu_data,
    input  lsu_valid, lsu_rdc, lsu_data, lsu_addr_lo, lsu_funct3,
    output alu_ready, lsu_ready, RF_W, rdc, rd, lsu_err, lsu_busy
  );

  modport master (
    output alu_valid, alu_rdc, alu_data,
    output lsu_valid, lsu_rdc, lsu_data, lsu_addr_lo, lsu_funct3,
    input  alu_ready, lsu_ready, RF_W, rdc, rd, lsu_err, lsu_busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Small LSU result FIFO with a combinational head; the caller never pushes
// when full nor pops when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  wb_entry_t                    wdata_i,
  output wb_entry_t                    head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: extends load data, buffers LSU results and arbitrates
// ALU vs LSU onto the single registered regfile write port.
module wb_stage
  import wb_pkg::*;
#(
  parameter int LSU_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  wb_if.slave bus
);

  localparam int            CW       = $clog2(LSU_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(LSU_DEPTH);

  logic [CW-1:0]   count;
  wb_entry_t       head, push_entry, grant_entry;
  logic            full, nonempty, legal, lsu_fire, push, pop, grant_valid;
  logic [XLEN-1:0] shifted, ext;
  load_op_t        op;

  logic            rf_w_q, rf_w_d;
  logic [4:0]      rdc_q, rdc_d;
  logic [XLEN-1:0] rd_q, rd_d;
  logic            err_q, err_d;

  assign op      = load_op_t'(bus.lsu_funct3);
  assign shifted = bus.lsu_data >> {bus.lsu_addr_lo, 3'b000};
  assign legal   = !load_illegal(bus.lsu_funct3) &&
                   !load_misaligned(bus.lsu_funct3, bus.lsu_addr_lo);

  always_comb begin
    ext = shifted;
    case (op)
      LB:      ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      LBU:     ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
      LH:      ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LHU:     ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
      LW:      ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LWU:     ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  assign full     = (count == FULL_CNT);
  assign nonempty = (count != '0);
  assign lsu_fire = bus.lsu_valid && !full;
  assign push     = lsu_fire && legal;
  assign push_entry.rdc  = bus.lsu_rdc;
  assign push_entry.data = ext;

  // A full FIFO steals the port from the ALU so loads cannot starve.
  always_comb begin
    grant_valid = 1'b0;
    grant_entry = '0;
    pop         = 1'b0;
    if (bus.alu_valid && !full) begin
      grant_valid      = 1'b1;
      grant_entry.rdc  = bus.alu_rdc;
      grant_entry.data = bus.alu_data;
    end else if (nonempty) begin
      grant_valid = 1'b1;
      grant_entry = head;
      pop         = 1'b1;
    end
  end

  always_comb begin
    rf_w_d = grant_valid && (grant_entry.rdc != 5'd0);
    rdc_d  = rf_w_d ? grant_entry.rdc  : 5'd0;
    rd_d   = rf_w_d ? grant_entry.data : '0;
    err_d  = lsu_fire && !legal;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_w_q <= 1'b0;
      rdc_q  <= '0;
      rd_q   <= '0;
      err_q  <= 1'b0;
    end else begin
      rf_w_q <= rf_w_d;
      rdc_q  <= rdc_d;
      rd_q   <= rd_d;
      err_q  <= err_d;
    end
  end

  wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.alu_ready = !full;
  assign bus.lsu_ready = !full;
  assign bus.lsu_busy  = nonempty;
  assign bus.RF_W      = rf_w_q;
  assign bus.rdc       = rdc_q;
  assign bus.rd        = rd_q;
  assign bus.lsu_err   = err_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_stage;

  localparam int DEPTH = 2;

  typedef struct {
    logic [4:0]  rdc;
    logic [63:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  wb_if bus ();

  wb_stage #(.LSU_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  ent_t        mq[$];
  logic        exp_w, exp_err;
  logic [4:0]  exp_rdc;
  logic [63:0] exp_rd;
  bit          alu_acc, lsu_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Load result from the rules: access size, alignment, mask, optional sign fill.
  task automatic ref_load(input logic [2:0] f3, input logic [2:0] addr, input logic [63:0] data,
                          output bit legal, output logic [63:0] val);
    int          size;
    logic [63:0] mask;
    size  = 1 << f3[1:0];
    legal = (f3 != 3'b111) && ((int'(addr) % size) == 0);
    mask  = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
    val   = (data >> (8 * int'(addr))) & mask;
    if (!f3[2] && size < 8 && val[8 * size - 1]) val = val | ~mask;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_w = 0; exp_rdc = 0; exp_rd = 0; exp_err = 0;
  endtask

  task automatic set_idle();
    bus.alu_valid = 0; bus.alu_rdc = 0; bus.alu_data = 0;
    bus.lsu_valid = 0; bus.lsu_rdc = 0; bus.lsu_data = 0;
    bus.lsu_addr_lo = 0; bus.lsu_funct3 = 0;
  endtask

  // Called at a negedge with inputs applied; returns at the next negedge.
  task automatic cycle();
    bit          full, legal, gv;
    ent_t        g;
    logic [63:0] v;
    #1;
    full = (mq.size() == DEPTH);
    check("alu_ready", bus.alu_ready, !full);
    check("lsu_ready", bus.lsu_ready, !full);
    check("lsu_busy", bus.lsu_busy, mq.size() != 0);
    ref_load(bus.lsu_funct3, bus.lsu_addr_lo, bus.lsu_data, legal, v);
    gv = 0; g.rdc = 0; g.data = 0; alu_acc = 0;
    if (full && bus.alu_valid) begin
      gv = 1; g = mq.pop_front();
    end else if (bus.alu_valid) begin
      gv = 1; g.rdc = bus.alu_rdc; g.data = bus.alu_data; alu_acc = 1;
    end else if (mq.size() > 0) begin
      gv = 1; g = mq.pop_front();
    end
    lsu_acc = bus.lsu_valid && !full;
    if (lsu_acc && legal) mq.push_back('{bus.lsu_rdc, v});
    exp_w   = gv && (g.rdc != 0);
    exp_rdc = exp_w ? g.rdc : 5'd0;
    exp_rd  = exp_w ? g.data : 64'd0;
    exp_err = lsu_acc && !legal;
    @(negedge clk);
    check("RF_W", bus.RF_W, exp_w);
    check("rdc", bus.rdc, exp_rdc);
    check("rd", bus.rd, exp_rd);
    check("lsu_err", bus.lsu_err, exp_err);
    if (bus.RF_W) $display("t=%0t write x%0d = 0x%016h", $time, bus.rdc, bus.rd);
  endtask

  task automatic load(input logic [4:0] r, input logic [2:0] f3, input logic [2:0] a,
                      input logic [63:0] d);
    set_idle();
    bus.lsu_valid = 1; bus.lsu_rdc = r; bus.lsu_funct3 = f3;
    bus.lsu_addr_lo = a; bus.lsu_data = d;
    cycle();
    set_idle();
    cycle();
  endtask

  localparam logic [63:0] LDATA = 64'h8877_6655_4433_2281;

  initial begin
    ent_t obs[$];
    int   alu_sent, alu_seen, l_idx;

    rst = 1;
    set_idle();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_RF_W", bus.RF_W, 0);
    check("rst_rdc", bus.rdc, 0);
    check("rst_rd", bus.rd, 0);
    check("rst_err", bus.lsu_err, 0);
    check("rst_busy", bus.lsu_busy, 0);
    rst = 0;

    // Reset mid-write with a load also buffered.
    bus.alu_valid = 1; bus.alu_rdc = 5; bus.alu_data = 64'h1234;
    bus.lsu_valid = 1; bus.lsu_rdc = 7; bus.lsu_funct3 = 3'b011; bus.lsu_data = 64'h55;
    cycle();
    check("pre_rst_write", bus.rd, 64'h1234);
    rst = 1;
    #1;
    check("async_rst_RF_W", bus.RF_W, 0);
    check("async_rst_rd", bus.rd, 0);
    check("async_rst_busy", bus.lsu_busy, 0);
    set_idle();
    model_reset();
    @(negedge clk);
    rst = 0;
    cycle();

    // ALU writes, including x0 suppression.
    bus.alu_valid = 1; bus.alu_rdc = 3; bus.alu_data = 64'hDEAD_BEEF;
    cycle();
    check("alu_rd", bus.rd, 64'h0000_0000_DEAD_BEEF);
    check("alu_rdc", bus.rdc, 3);
    bus.alu_rdc = 0;
    cycle();
    check("alu_x0", bus.RF_W, 0);
    set_idle();
    cycle();

    load(1, 3'b000, 0, LDATA); check("lb", bus.rd, 64'hFFFF_FFFF_FFFF_FF81);
    load(2, 3'b100, 0, LDATA); check("lbu", bus.rd, 64'h81);
    load(3, 3'b010, 4, LDATA); check("lw", bus.rd, 64'hFFFF_FFFF_8877_6655);
    load(4, 3'b101, 6, LDATA); check("lhu", bus.rd, 64'h8877);

    // Misaligned and illegal loads.
    set_idle();
    bus.lsu_valid = 1; bus.lsu_rdc = 9; bus.lsu_funct3 = 3'b010; bus.lsu_addr_lo = 2;
    bus.lsu_data = LDATA;
    cycle();
    check("mis_err", bus.lsu_err, 1);
    check("mis_nowrite", bus.RF_W, 0);
    set_idle();
    cycle();
    check("mis_err_pulse", bus.lsu_err, 0);
    bus.lsu_valid = 1; bus.lsu_rdc = 9; bus.lsu_funct3 = 3'b111;
    cycle();
    check("ill_err", bus.lsu_err, 1);
    set_idle();
    cycle();
    check("ill_err_pulse", bus.lsu_err, 0);
    check("ill_nowrite", bus.RF_W, 0);

    // Contention: ALU always valid while three loads arrive.
    alu_sent = 0; alu_seen = 0; l_idx = 0;
    for (int i = 0; i < 16; i++) begin
      bus.alu_valid = (i < 10);
      bus.alu_rdc   = 5'(20 + (alu_sent % 8));
      bus.alu_data  = 64'hA000 + 64'(alu_sent);
      bus.lsu_valid = (l_idx < 3);
      bus.lsu_rdc   = 5'(10 + l_idx);
      bus.lsu_funct3 = 3'b011; bus.lsu_addr_lo = 0;
      bus.lsu_data  = 64'h100 + 64'(l_idx);
      cycle();
      if (alu_acc) alu_sent++;
      if (lsu_acc) l_idx++;
      if (bus.RF_W && bus.rdc >= 10 && bus.rdc <= 12) obs.push_back('{bus.rdc, bus.rd});
      if (bus.RF_W && bus.rdc >= 20) alu_seen++;
    end
    check("cont_nloads", obs.size(), 3);
    for (int k = 0; k < 3 && k < obs.size(); k++)
      check("cont_order", obs[k].rdc, 5'(10 + k));
    check("cont_alu_lost", alu_seen, alu_sent);

    // Back-to-back push/pop holding one entry.
    set_idle();
    repeat (2) cycle();
    bus.lsu_valid = 1; bus.lsu_funct3 = 3'b011; bus.lsu_rdc = 1; bus.lsu_data = 64'h5000;
    cycle();
    for (int i = 0; i < 8; i++) begin
      bus.lsu_rdc  = 5'(2 + i);
      bus.lsu_data = 64'h5001 + 64'(i);
      cycle();
      check("b2b_busy", bus.lsu_busy, 1);
      check("b2b_rdc", bus.rdc, 5'(1 + i));
    end
    set_idle();
    repeat (2) cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bus.alu_valid   = ($urandom_range(0, 99) < 50);
      bus.alu_rdc     = 5'($urandom_range(0, 31));
      bus.alu_data    = {$urandom, $urandom};
      bus.lsu_valid   = ($urandom_range(0, 99) < 50);
      bus.lsu_rdc     = 5'($urandom_range(0, 31));
      bus.lsu_data    = {$urandom, $urandom};
      bus.lsu_funct3  = 3'($urandom_range(0, 7));
      bus.lsu_addr_lo = $urandom_range(0, 1) ? 3'd0 : 3'($urandom_range(0, 7));
      cycle();
    end
    set_idle();
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
